ct_spsram_8192x32_ctrl: RTL and testbench
=========================================

// Module: ct_spsram_8192x32_ctrl
// PURPOSE
//  Request/response front-end for the 8192x32 single-port SRAM macro wrapper.
//  Turns a valid/ready read/byte-write request port into active-low SRAM pins
//  (CEN/GWEN/per-bit WEN) and captures Q into a 3-entry response FIFO.
//  Zero-fills the whole array after reset and on demand (init_req).
//  Sits between the LSU buffer logic and the SRAM wrapper.
// PARAMETERS
//  ADDR_WIDTH  13    SRAM address width; array depth = 2**ADDR_WIDTH = 8192
//  DATA_WIDTH  32    data width; byte enables = DATA_WIDTH/8
// PORTS
//  forever_cpuclk  in   1   clock
//  cpurst          in   1   asynchronous reset, active-high
//  init_req        in   1   pulse: re-zero the whole array
//  init_busy       out  1   1 while state != RUN
//  req_vld         in   1   request valid
//  req_rdy         out  1   request ready
//  req_wr          in   1   1 = write, 0 = read
//  req_addr        in   13  word address
//  req_wdata       in   32  write data
//  req_be          in   4   byte enables, active-high; be[i] covers bits 8i+7:8i
//  rsp_vld         out  1   read data valid
//  rsp_rdy         in   1   read data accepted
//  rsp_rdata       out  32  read data
//  sram_a          out  13  to SRAM A
//  sram_cen        out  1   to SRAM CEN, active-low
//  sram_gwen       out  1   to SRAM GWEN, active-low global write
//  sram_wen        out  32  to SRAM WEN, active-low per-bit write
//  sram_d          out  32  to SRAM D
//  sram_q          in   32  from SRAM Q, valid in the cycle after a read access
// BEHAVIOUR
//  Reset (cpurst=1, async):
//   - State=INIT, init_cnt=0, FIFO empty, rd_inflight=0.
//   - req_rdy=0, rsp_vld=0, rsp_rdata=0, init_busy=1.
//   - While cpurst is high: sram_cen=1, sram_gwen=1, sram_wen=all 1s.
//  FSM states: INIT, RUN, DRAIN.
//   - INIT: each cycle write 0 to addr init_cnt. Pins: cen=0, gwen=0, wen=0, d=0.
//     Increment init_cnt; after writing addr 8191, next state is RUN and init_cnt
//     returns to 0. Sequence takes 8192 cycles. init_req is ignored in INIT/DRAIN.
//   - RUN: init_req=1 -> DRAIN at the next edge. A request handshaking in that
//     same cycle still completes.
//   - DRAIN: req_rdy=0. Go to INIT when rd_inflight=0.
//     FIFO contents are kept and remain poppable.
//  req_rdy = (state==RUN) && (fifo_cnt + rd_inflight < 3).
//   - No combinational path from rsp_rdy or req_vld to req_rdy.
//  SRAM pins are combinational from the request when state==RUN and req_vld&req_rdy.
//   - Idle: cen=1, gwen=1, wen=all 1s.
//   - a=req_addr, d=req_wdata.
//   - Read: cen=0, gwen=1.
//   - Write: gwen=0, wen[8i+7:8i]=~{8{be[i]}}. cen=0 if be!=0; if be==0 the
//     write is accepted and cen=1 (no access).
//   - Writes produce no response.
//  Read pipeline:
//   - Read accepted at edge t sets rd_inflight=1.
//   - sram_q is pushed into the FIFO at edge t+1; rsp_vld=1 from cycle t+1.
//   - Reads accepted on consecutive cycles overlap; rd_inflight is a single bit
//     refreshed every cycle.
//  FIFO: 3 entries, in-order, registered.
//   - rsp_vld = fifo_cnt != 0; rsp_rdata = head entry, 0 when empty.
//   - Push and pop in the same cycle are allowed; count is unchanged.
//   - Overflow is impossible by construction of req_rdy.
//  Hazards:
//   - Write then read to the same address in the next cycle returns the new data.
//   - Byte-masked bytes keep their old value.
//  Reset mid-INIT or mid-read: all state is discarded; INIT restarts from addr 0.
// TESTING
//  1. Release reset.
//     -> init_busy=1 for 8192 cycles with sram_a counting 0..8191, cen=0, gwen=0.
//     -> Then RUN, req_rdy=1. Reading 0x1FFF returns 0x00000000.
//  2. Write 0x1234 data=0xDEADBEEF be=4'hF, then write be=4'b0010 data=0x0000AA00,
//     then read 0x1234. -> rsp_rdata=0xDEADAAEF one cycle after read acceptance.
//  3. Back-to-back reads of addrs 0..9 with rsp_rdy=1.
//     -> One read accepted per cycle; 10 responses in order, no bubbles.
//  4. Same as 3 with rsp_rdy=0. -> Exactly 3 reads accepted, req_rdy=0, rsp_vld=1.
//     Raise rsp_rdy -> 3 in-order responses, then acceptance resumes.
//  5. Write with be=0. -> Handshake completes, sram_cen stays 1, memory unchanged.
//  6. Read accepted, init_req in the same cycle.
//     -> DRAIN then INIT; the read response is still delivered.
//     -> After 8192 cycles all addresses read 0.
//     -> Async reset asserted mid-INIT: outputs return to reset values immediately.

Source files
------------

// File: rtl/ct_spsram_8192x32_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// ct_spsram_8192x32_ctrl_if : request/response bus of the SRAM front-end
// Revision: 1.0
// ============================================================================
interface ct_spsram_8192x32_ctrl_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic                      req_vld;
  logic                      req_rdy;
  logic                      req_wr;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_be;
  logic                      rsp_vld;
  logic                      rsp_rdy;
  logic [DATA_WIDTH-1:0]     rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/ct_spsram_8192x32_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// ct_spsram_8192x32_ctrl : valid/ready front-end for the 8192x32 SP-SRAM with
//                          3-entry read response FIFO and zero-fill on init.
// Revision: 1.0
// ============================================================================
module ct_spsram_8192x32_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                   forever_cpuclk,
  input  wire logic                   cpurst,
  input  wire logic                   init_req,
  output logic                        init_busy,
  ct_spsram_8192x32_ctrl_if.slave     bus,
  output logic [ADDR_WIDTH-1:0]       sram_a,
  output logic                        sram_cen,
  output logic                        sram_gwen,
  output logic [DATA_WIDTH-1:0]       sram_wen,
  output logic [DATA_WIDTH-1:0]       sram_d,
  input  wire logic [DATA_WIDTH-1:0]  sram_q
);

  localparam int                    c_BE_WIDTH   = DATA_WIDTH / 8;
  localparam logic [2:0]            c_FIFO_DEPTH = 3'd3;
  localparam logic [1:0]            c_LAST_PTR   = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] c_INIT_LAST  = '1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_init_cnt;
  logic                    r_rd_inflight;
  logic [DATA_WIDTH-1:0]   r_fifo_mem [0:2];
  logic [1:0]              r_wr_ptr;
  logic [1:0]              r_rd_ptr;
  logic [1:0]              r_fifo_cnt;

  logic                    w_req_rdy;
  logic                    w_accept;
  logic                    w_rd_accept;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_nempty;
  logic [DATA_WIDTH-1:0]   w_wen_write;

  // Ready looks only at registered state, so it never depends on req_vld/rsp_rdy.
  assign w_req_rdy     = (r_state == ST_RUN) &&
                         (({1'b0, r_fifo_cnt} + {2'b00, r_rd_inflight}) < c_FIFO_DEPTH);
  assign w_accept      = bus.req_vld & w_req_rdy;
  assign w_rd_accept   = w_accept & ~bus.req_wr;
  assign w_push        = r_rd_inflight;
  assign w_fifo_nempty = (r_fifo_cnt != 2'd0);
  assign w_pop         = w_fifo_nempty & bus.rsp_rdy;

  assign bus.req_rdy   = w_req_rdy;
  assign bus.rsp_vld   = w_fifo_nempty;
  assign bus.rsp_rdata = w_fifo_nempty ? r_fifo_mem[r_rd_ptr] : '0;
  assign init_busy     = (r_state != ST_RUN);

  for (genvar gi = 0; gi < c_BE_WIDTH; gi++) begin : g_wen
    assign w_wen_write[8*gi +: 8] = {8{~bus.req_be[gi]}};
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    sram_a      = bus.req_addr;
    sram_d      = bus.req_wdata;
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = '1;

    unique case (r_state)
      ST_INIT:  if (r_init_cnt == c_INIT_LAST) w_state_nxt = ST_RUN;
      ST_RUN:   if (init_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_rd_inflight) w_state_nxt = ST_INIT;
      default:  w_state_nxt = ST_INIT;
    endcase

    // Pins are forced idle for as long as reset is held, regardless of state.
    if (cpurst) begin
      sram_cen = 1'b1;
    end else if (r_state == ST_INIT) begin
      sram_a    = r_init_cnt;
      sram_d    = '0;
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
    end else if (w_accept) begin
      if (bus.req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = w_wen_write;
        sram_cen  = ~(|bus.req_be);
      end else begin
        sram_cen  = 1'b0;
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_init_cnt    <= '0;
      r_rd_inflight <= 1'b0;
      r_wr_ptr      <= 2'd0;
      r_rd_ptr      <= 2'd0;
      r_fifo_cnt    <= 2'd0;
    end else begin
      r_init_cnt    <= (r_state == ST_INIT) ? r_init_cnt + 1'b1 : '0;
      r_rd_inflight <= w_rd_accept;
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? 2'd0 : r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? 2'd0 : r_rd_ptr + 2'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Entry storage needs no reset: only slots below the count are ever visible.
  always_ff @(posedge forever_cpuclk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= sram_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ct_spsram_8192x32_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_ct_spsram_8192x32_ctrl : bench with behavioural SRAM and reference memory
// Revision: 1.0
// ============================================================================
module tb_ct_spsram_8192x32_ctrl;
  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_req = 1'b0;
  logic          init_busy;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;

  ct_spsram_8192x32_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ct_spsram_8192x32_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .init_req       (init_req),
    .init_busy      (init_busy),
    .bus            (bus),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macro: active-low enables, per-bit write mask, Q one cycle later.
  logic [DW-1:0] sram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: word array + expected-response queue; the array reads as zero after any busy period.
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_word;
  logic          clear_pending = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      clear_pending = 1'b1;
    end else begin
      if (init_busy) begin
        clear_pending = 1'b1;
      end else if (clear_pending) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        clear_pending = 1'b0;
      end
      if (bus.rsp_vld && bus.rsp_rdy) begin
        check("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check("rsp_data", bus.rsp_rdata, exp_word);
        end
        pops++;
      end
      if (bus.req_vld && bus.req_rdy) begin
        if (bus.req_wr) begin
          for (int b = 0; b < DW/8; b++) begin
            if (bus.req_be[b]) ref_mem[bus.req_addr][8*b +: 8] = bus.req_wdata[8*b +: 8];
          end
        end else begin
          exp_q.push_back(ref_mem[bus.req_addr]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [3:0] be, output logic cen_acc);
    logic ok;
    ok = 1'b0;
    cen_acc = 1'b1;
    bus.req_vld = 1'b1; bus.req_wr = wr; bus.req_addr = addr; bus.req_wdata = wd; bus.req_be = be;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_rdy) begin ok = 1'b1; cen_acc = sram_cen; end
      tick();
    end
    bus.req_vld = 1'b0;
    check("req_handshake", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(output logic [DW-1:0] data, output int lat);
    logic got;
    got = 1'b0; lat = 0; data = '0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_vld) begin got = 1'b1; lat = i; data = bus.rsp_rdata; end
    end
    check("rsp_arrives", 32'(got), 32'd1);
    tick();
  endtask

  task automatic run_reads(input int base, input int n, input int budget, output int acc, output int cyc);
    acc = 0; cyc = 0;
    bus.req_wr = 1'b0;
    while (acc < n && cyc < budget) begin
      bus.req_vld = 1'b1; bus.req_addr = AW'(base + acc);
      @(negedge clk); cyc++;
      if (bus.req_rdy) acc++;
      tick();
    end
    bus.req_vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !bus.rsp_vld) idle = 1'b1;
    end
    check("drain_idle", 32'(idle), 32'd1);
    tick();
  endtask

  task automatic count_busy(output int busy, output logic [AW-1:0] first_a);
    logic done;
    done = 1'b0; busy = 0; first_a = '1;
    for (int i = 0; i < 9000 && !done; i++) begin
      @(negedge clk);
      if (i == 0) first_a = sram_a;
      if (init_busy) busy++; else done = 1'b1;
      tick();
      init_req = (i == 100);
    end
    init_req = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          cen;
    logic [AW-1:0] a0;
    int lat, acc, cyc, bad, busy, p0;

    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_be = '0; bus.rsp_rdy = 1'b1;

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy",   32'(bus.req_rdy), 32'd0);
    check("rst_rsp_vld",   32'(bus.rsp_vld), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata,    32'd0);
    check("rst_init_busy", 32'(init_busy),   32'd1);
    check("rst_cen",       32'(sram_cen),    32'd1);
    check("rst_gwen",      32'(sram_gwen),   32'd1);
    check("rst_wen",       sram_wen,         32'hFFFF_FFFF);
    tick();
    rst = 1'b0;

    // Zero-fill sweep after reset
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (sram_a !== AW'(i) || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
          sram_wen !== '0 || sram_d !== '0 || init_busy !== 1'b1) bad++;
    end
    check("init_sweep_bad_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    check("run_init_busy", 32'(init_busy),   32'd0);
    check("run_req_rdy",   32'(bus.req_rdy), 32'd1);
    tick();

    do_req(1'b0, 13'h1FFF, '0, 4'h0, cen);
    wait_rsp(d, lat);
    check("rd_top_data", d, 32'h0000_0000);
    check("rd_latency", 32'(lat), 32'd2);

    // Byte-masked overwrite followed immediately by a read of the same word
    do_req(1'b1, 13'h1234, 32'hDEAD_BEEF, 4'hF, cen);
    do_req(1'b1, 13'h1234, 32'h0000_AA00, 4'b0010, cen);
    do_req(1'b0, 13'h1234, '0, 4'h0, cen);
    wait_rsp(d, lat);
    check("rd_merged", d, 32'hDEAD_AAEF);

    // Empty byte enable: handshake, no access
    do_req(1'b1, 13'h1234, 32'h5555_5555, 4'h0, cen);
    check("be0_cen", 32'(cen), 32'd1);
    do_req(1'b0, 13'h1234, '0, 4'h0, cen);
    wait_rsp(d, lat);
    check("be0_unchanged", d, 32'hDEAD_AAEF);

    // Random traffic over a small window to hit hazards and backpressure
    for (int c = 0; c < 400; c++) begin
      bus.req_vld   = 1'($urandom_range(0, 1));
      bus.req_wr    = 1'($urandom_range(0, 1));
      bus.req_addr  = AW'($urandom_range(0, 31));
      bus.req_wdata = $urandom;
      bus.req_be    = 4'($urandom);
      bus.rsp_rdy   = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.req_vld = 1'b0; bus.rsp_rdy = 1'b1;
    wait_idle(50);

    // Back-to-back reads, no backpressure
    p0 = pops;
    run_reads(0, 10, 40, acc, cyc);
    check("b2b_accepted", 32'(acc), 32'd10);
    check("b2b_cycles",   32'(cyc), 32'd10);
    @(negedge clk); @(negedge clk); #1;
    check("b2b_rsp_count", 32'(pops - p0), 32'd10);
    tick();
    wait_idle(20);

    // Backpressure fills the FIFO, then resumes
    bus.rsp_rdy = 1'b0;
    p0 = pops;
    run_reads(0, 10, 8, acc, cyc);
    check("bp_accepted", 32'(acc), 32'd3);
    @(negedge clk);
    check("bp_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("bp_rsp_vld", 32'(bus.rsp_vld), 32'd1);
    tick();
    bus.rsp_rdy = 1'b1;
    run_reads(3, 7, 40, acc, cyc);
    check("bp_resume_accepted", 32'(acc), 32'd7);
    wait_idle(20);
    check("bp_rsp_count", 32'(pops - p0), 32'd10);

    // init_req together with an accepted read
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 13'h0007; init_req = 1'b1;
    @(negedge clk);
    check("drain_rd_accept", 32'(bus.req_rdy), 32'd1);
    tick();
    bus.req_vld = 1'b0; init_req = 1'b0;
    count_busy(busy, a0);
    check("drain_init_cycles", 32'(busy), 32'd8194);
    check("drain_rsp_delivered", 32'(exp_q.size()), 32'd0);
    run_reads(0, DEPTH, 9000, acc, cyc);
    check("zero_sweep_accepted", 32'(acc), 32'(DEPTH));
    wait_idle(20);

    // Async reset in the middle of INIT with a response still parked
    bus.rsp_rdy = 1'b0;
    do_req(1'b0, 13'h0003, '0, 4'h0, cen);
    tick(); tick();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    repeat (50) tick();
    check("midinit_busy",     32'(init_busy),   32'd1);
    check("midinit_fifo_kept", 32'(bus.rsp_vld), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_cen",     32'(sram_cen),    32'd1);
    check("arst_gwen",    32'(sram_gwen),   32'd1);
    check("arst_wen",     sram_wen,         32'hFFFF_FFFF);
    check("arst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("arst_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("arst_busy",    32'(init_busy),   32'd1);
    tick(); tick();
    rst = 1'b0;
    bus.rsp_rdy = 1'b1;
    count_busy(busy, a0);
    check("rst_restart_addr",  32'(a0),   32'd0);
    check("rst_restart_cycles", 32'(busy), 32'd8192);
    do_req(1'b0, 13'h0003, '0, 4'h0, cen);
    wait_rsp(d, lat);
    check("post_rst_rd", d, 32'h0000_0000);
    wait_idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
